aes_ctr_ctrl: RTL and testbench
===============================

// Module: aes_ctr_ctrl
// PURPOSE
//  CTR-mode stream controller sitting directly upstream of the AES-128 core.
//  - Loads a 128-bit initial counter block (nonce||counter).
//  - Feeds counter blocks to the core's encrypt port and captures the keystream on encrypt_done.
//  - XORs the keystream with a valid/ready data stream. The same path serves encryption and
//    decryption; the core's decrypt port is never used.
// PARAMETERS
//  COUNTER_W  32  width of the incrementing low field of the counter block (1..128)
// PORTS
//  clk              in   1    clock, rising edge
//  rst              in   1    synchronous reset, active-high
//  start_i          in   1    load iv_i and begin a stream; honoured only in IDLE
//  iv_i             in   128  initial counter block
//  key_ready_i      in   1    key expansion complete (sticky from gen_key_done, held by integrator)
//  aes_encrypt_o    out  1    one-cycle encrypt request to core
//  aes_block_o      out  128  counter block to core plaintext input
//  aes_busy_i       in   1    core encrypt_busy
//  aes_done_i       in   1    core encrypt_done pulse
//  aes_result_i     in   128  core ciphertext output, sampled on aes_done_i
//  in_valid_i       in   1    input data valid
//  in_ready_o       out  1    input data accepted this cycle
//  in_data_i        in   128  plaintext or ciphertext block
//  in_last_i        in   1    final block of stream
//  out_valid_o      out  1    output data valid
//  out_ready_i      in   1    downstream accepts output
//  out_data_o       out  128  in_data XOR keystream
//  out_last_o       out  1    final block marker
//  busy_o           out  1    state != IDLE
//  ctr_wrap_o       out  1    sticky: low COUNTER_W field wrapped this stream
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0. Counter, keystream and output registers 0.
//  - FSM states and transitions:
//    - IDLE: on start_i, ctr<=iv_i, clear ctr_wrap_o, go REQ.
//    - REQ: when key_ready_i && !aes_busy_i, drive aes_encrypt_o=1 for exactly one cycle with
//      aes_block_o=ctr, then go WAIT. Otherwise hold in REQ with aes_encrypt_o=0.
//    - WAIT: on aes_done_i, ks<=aes_result_i, ctr[COUNTER_W-1:0]++ (upper bits untouched), go HAVE_KS.
//      aes_done_i outside WAIT is ignored, e.g. a stale completion after reset.
//    - HAVE_KS: in_ready_o = !out_valid_o || out_ready_i. On in_valid_i && in_ready_o, register
//      out_data_o<=in_data_i^ks and out_last_o<=in_last_i, set out_valid_o. Then go IDLE if
//      in_last_i, else go REQ (prefetch next keystream).
//  - in_ready_o is 0 in every state except HAVE_KS. Each keystream block is used exactly once.
//  - Output handshake: out_valid_o holds with stable data until out_ready_i. Output and input may
//    transfer in the same cycle (single register, pass-through on ready).
//  - aes_block_o is held stable from REQ through WAIT.
//  - Counter: low field increments mod 2^COUNTER_W. The increment that rolls the field from all-1
//    to 0 sets ctr_wrap_o, which stays set until the next accepted start_i. Streaming continues.
//  - Latency: first out_valid_o comes 1 cycle after the input handshake. The input handshake
//    follows aes_done_i by >=1 cycle.
//  - start_i outside IDLE is ignored.
//  - rst mid-stream aborts the stream. A pending output is dropped. Core-side cleanup belongs to
//    the core's own reset.
//  - The final output may still be pending when the FSM returns to IDLE. A new start_i is legal
//    then, and the pending output still drains.
// STRUCTURE
//  - Package aes_pkg: typedef block_t (logic [127:0]), enum ctr_state_e {IDLE,REQ,WAIT,HAVE_KS},
//    constant BLOCK_W=128.
//  - Sub-module aes_ctr_inc: combinational COUNTER_W-bit increment with carry-out, carry used as
//    the wrap flag.
//  - FSM, keystream register and output register stay in this module.
// TESTING
//  - FIPS SP800-38A F.5.1: key 2b7e1516..., iv f0f1...feff, 4 blocks 6bc1bee2... ->
//    out_data 874d6191..., 9806f66b..., 5ae4df3e..., 1e031dda...; out_last on block 4.
//  - Decrypt: feed the F.5.1 ciphertext with the same iv -> original plaintext returned bit-exact.
//  - Wrap: COUNTER_W=8, iv low byte ff, 2 blocks -> second aes_block_o low byte 00, upper 120 bits
//    unchanged, ctr_wrap_o=1 until next start.
//  - Backpressure: out_ready_i low 5 cycles mid-stream -> out_data stable and in_ready_o=0 for the
//    whole stall. No keystream skipped (compare with the golden model).
//  - key_ready_i=0 at start -> FSM stays in REQ with aes_encrypt_o=0. Raise key_ready_i -> exactly
//    one aes_encrypt_o pulse.
//  - rst asserted in WAIT, then a stray aes_done_i -> stays IDLE, outputs 0, no output beat.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the AES-128 CTR-mode stream controller and its sub-blocks.
package aes_pkg;
    localparam int BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HAVE_KS
    } ctr_state_e;
endpackage

// File: rtl/aes_ctr_ctrl_if.sv
// Core-side request/completion signals plus the valid/ready data streams of the CTR controller.
interface aes_ctr_ctrl_if;
    import aes_pkg::*;

    logic   aes_encrypt_o;
    block_t aes_block_o;
    logic   aes_busy_i;
    logic   aes_done_i;
    block_t aes_result_i;

    logic   in_valid_i;
    logic   in_ready_o;
    block_t in_data_i;
    logic   in_last_i;

    logic   out_valid_o;
    logic   out_ready_i;
    block_t out_data_o;
    logic   out_last_o;

    // master is the controller's view; slave is the core plus stream endpoints
    modport master (
        output aes_encrypt_o, aes_block_o, in_ready_o, out_valid_o, out_data_o, out_last_o,
        input  aes_busy_i, aes_done_i, aes_result_i, in_valid_i, in_data_i, in_last_i,
               out_ready_i
    );

    modport slave (
        input  aes_encrypt_o, aes_block_o, in_ready_o, out_valid_o, out_data_o, out_last_o,
        output aes_busy_i, aes_done_i, aes_result_i, in_valid_i, in_data_i, in_last_i,
               out_ready_i
    );
endinterface

// File: rtl/aes_ctr_inc.sv
// Increment of the low counter field; the carry-out marks the roll from all-ones to zero.
module aes_ctr_inc #(
    parameter int COUNTER_W = 32
) (
    input  logic [COUNTER_W-1:0] i_val,
    output logic [COUNTER_W-1:0] o_val,
    output logic                 o_carry
);
    assign {o_carry, o_val} = {1'b0, i_val} + {{COUNTER_W{1'b0}}, 1'b1};
endmodule

// File: rtl/aes_ctr_ctrl.sv
// CTR-mode controller: fetches one keystream block per data beat from the AES core and
// XORs it into a valid/ready stream (same path for encrypt and decrypt).
module aes_ctr_ctrl
    import aes_pkg::*;
#(
    parameter int COUNTER_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start_i,
    input  block_t iv_i,
    input  logic   key_ready_i,
    output logic   busy_o,
    output logic   ctr_wrap_o,
    aes_ctr_ctrl_if.master bus
);
    ctr_state_e r_state;
    block_t     r_ctr;
    block_t     r_ks;
    block_t     r_outData;
    logic       r_encrypt;
    logic       r_outValid;
    logic       r_outLast;
    logic       r_wrap;

    logic [COUNTER_W-1:0] w_ctrLowNext;
    logic                 w_carry;
    block_t               w_ctrNext;
    logic                 w_inReady;
    logic                 w_inFire;

    aes_ctr_inc #(.COUNTER_W(COUNTER_W)) u_inc (
        .i_val   (r_ctr[COUNTER_W-1:0]),
        .o_val   (w_ctrLowNext),
        .o_carry (w_carry)
    );

    // Only the low field advances; the nonce part above it is never touched.
    generate
        if (COUNTER_W < BLOCK_W) begin : g_partial
            assign w_ctrNext = {r_ctr[BLOCK_W-1:COUNTER_W], w_ctrLowNext};
        end else begin : g_full
            assign w_ctrNext = w_ctrLowNext;
        end
    endgenerate

    assign w_inReady = (r_state == HAVE_KS) && (!r_outValid || bus.out_ready_i);
    assign w_inFire  = w_inReady && bus.in_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ctr      <= '0;
            r_ks       <= '0;
            r_outData  <= '0;
            r_encrypt  <= 1'b0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_encrypt <= 1'b0;
            if (r_outValid && bus.out_ready_i) begin
                r_outValid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_ctr   <= iv_i;
                        r_wrap  <= 1'b0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (key_ready_i && !bus.aes_busy_i) begin
                        r_encrypt <= 1'b1;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.aes_done_i) begin
                        r_ks    <= bus.aes_result_i;
                        r_ctr   <= w_ctrNext;
                        r_state <= HAVE_KS;
                        if (w_carry) begin
                            r_wrap <= 1'b1;
                        end
                    end
                end
                HAVE_KS: begin
                    // A beat may load while the previous one leaves (pass-through on ready).
                    if (w_inFire) begin
                        r_outData  <= bus.in_data_i ^ r_ks;
                        r_outLast  <= bus.in_last_i;
                        r_outValid <= 1'b1;
                        r_state    <= bus.in_last_i ? IDLE : REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.aes_encrypt_o = r_encrypt;
    assign bus.aes_block_o   = r_ctr;
    assign bus.in_ready_o    = w_inReady;
    assign bus.out_valid_o   = r_outValid;
    assign bus.out_data_o    = r_outData;
    assign bus.out_last_o    = r_outLast;
    assign busy_o            = (r_state != IDLE);
    assign ctr_wrap_o        = r_wrap;
endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Directed scoreboard bench for aes_ctr_ctrl: an AES core model answers encrypt requests and
// expected output beats are queued as inputs are driven.
module tb_aes_ctr_ctrl;
    import aes_pkg::*;

    typedef struct {
        block_t d;
        logic   l;
    } beat_t;

    localparam block_t IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam block_t IV2 = 128'h0123456789abcdef00000000fffffffe;
    localparam block_t IV8 = 128'h00112233445566778899aabbccddeeff;
    localparam block_t PT [0:3] = '{
        128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    localparam block_t CT [0:3] = '{
        128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdab,
        128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};

    logic   clk = 1'b0;
    logic   rst, start, keyReady, busy, wrap;
    block_t iv;
    logic   rst8, start8, keyReady8, busy8, wrap8;
    block_t iv8;

    int     checks = 0;
    int     errors = 0;
    beat_t  sbQ[$];
    block_t encIv;
    int     encIdx;
    int     encCount;

    aes_ctr_ctrl_if bus ();
    aes_ctr_ctrl_if bus8 ();

    aes_ctr_ctrl #(.COUNTER_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .iv_i(iv), .key_ready_i(keyReady),
        .busy_o(busy), .ctr_wrap_o(wrap), .bus(bus)
    );

    aes_ctr_ctrl #(.COUNTER_W(8)) dut8 (
        .clk(clk), .rst(rst8), .start_i(start8), .iv_i(iv8), .key_ready_i(keyReady8),
        .busy_o(busy8), .ctr_wrap_o(wrap8), .bus(bus8)
    );

    always #5 clk = ~clk;

    // Counter block k of a stream: low w bits advance mod 2^w, upper bits stay as in the iv.
    function automatic block_t ctrAt(block_t base, int k, int w);
        block_t mask;
        block_t sum;
        mask = (w >= 128) ? '1 : ((block_t'(1) << w) - block_t'(1));
        sum  = base + block_t'(k);
        return (base & ~mask) | (sum & mask);
    endfunction

    // Core stand-in: real AES-128 keystream for the F.5.1 counters, an arbitrary mix elsewhere.
    function automatic block_t ksFn(block_t c);
        for (int i = 0; i < 4; i++) begin
            if (c == ctrAt(IV, i, 32)) return PT[i] ^ CT[i];
        end
        return {c[63:0], c[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    function automatic block_t genData(int k);
        return {4{32'hdead0000 + 32'(k)}};
    endfunction

    // Core model for the 32-bit instance, with a separate stray-done injection.
    block_t coreBlk = '0, coreRes = '0;
    logic   coreBusy = 1'b0, coreDone = 1'b0, strayDone = 1'b0;
    int     coreCnt = 0;
    assign bus.aes_busy_i   = coreBusy;
    assign bus.aes_done_i   = coreDone | strayDone;
    assign bus.aes_result_i = coreRes;

    always @(posedge clk) begin
        coreDone <= 1'b0;
        if (coreCnt != 0) begin
            coreCnt <= coreCnt - 1;
            if (coreCnt == 1) begin
                coreDone <= 1'b1;
                coreBusy <= 1'b0;
                coreRes  <= ksFn(coreBlk);
            end
        end else if (bus.aes_encrypt_o) begin
            coreBlk  <= bus.aes_block_o;
            coreCnt  <= 3;
            coreBusy <= 1'b1;
        end
    end

    // Core model for the 8-bit-counter instance.
    block_t coreBlk8 = '0, coreRes8 = '0;
    logic   coreBusy8 = 1'b0, coreDone8 = 1'b0;
    int     coreCnt8 = 0;
    assign bus8.aes_busy_i   = coreBusy8;
    assign bus8.aes_done_i   = coreDone8;
    assign bus8.aes_result_i = coreRes8;

    always @(posedge clk) begin
        coreDone8 <= 1'b0;
        if (coreCnt8 != 0) begin
            coreCnt8 <= coreCnt8 - 1;
            if (coreCnt8 == 1) begin
                coreDone8 <= 1'b1;
                coreBusy8 <= 1'b0;
                coreRes8  <= ksFn(coreBlk8);
            end
        end else if (bus8.aes_encrypt_o) begin
            coreBlk8  <= bus8.aes_block_o;
            coreCnt8  <= 2;
            coreBusy8 <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: sample the settled pre-edge state, score encrypt requests and output beats.
    task automatic step(output bit acc);
        beat_t b;
        #1;
        acc = bus.in_valid_i && bus.in_ready_o;
        if (bus.aes_encrypt_o) begin
            checkOutput("aes_block", bus.aes_block_o, ctrAt(encIv, encIdx, 32));
            encIdx++;
            encCount++;
        end
        if (bus.out_valid_o && bus.out_ready_i) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_beat", 1'b1, 1'b0);
            end else begin
                b = sbQ.pop_front();
                checkOutput("out_data", bus.out_data_o, b.d);
                checkOutput("out_last", bus.out_last_o, b.l);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic startStream(input block_t v);
        bit acc;
        encIv    = v;
        encIdx   = 0;
        encCount = 0;
        iv       = v;
        start    = 1'b1;
        step(acc);
        start    = 1'b0;
    endtask

    task automatic applyStimulus(input block_t data, input logic last, input block_t expData);
        bit acc;
        int n;
        beat_t b;
        b.d = expData;
        b.l = last;
        sbQ.push_back(b);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = data;
        bus.in_last_i  = last;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            step(acc);
            n++;
        end
        bus.in_valid_i = 1'b0;
        if (!acc) checkOutput("in_timeout", 1'b0, 1'b1);
        checkOutput("out_valid_latency", bus.out_valid_o, 1'b1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 50 && sbQ.size() != 0; i++) step(acc);
        checkOutput("drain_empty", 128'(sbQ.size()), 128'd0);
    endtask

    initial begin : stim
        bit     acc;
        block_t blk8[$];
        int     nOut, nAcc;
        bit     accNow;

        rst = 1'b1; start = 1'b0; iv = '0; keyReady = 1'b1;
        rst8 = 1'b1; start8 = 1'b0; iv8 = '0; keyReady8 = 1'b1;
        bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_last_i = 1'b0; bus.out_ready_i = 1'b1;
        bus8.in_valid_i = 1'b0; bus8.in_data_i = '0; bus8.in_last_i = 1'b0; bus8.out_ready_i = 1'b1;
        encIv = '0; encIdx = 0; encCount = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst8 = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wrap", wrap, 1'b0);
        checkOutput("rst_encrypt", bus.aes_encrypt_o, 1'b0);
        checkOutput("rst_block", bus.aes_block_o, 128'd0);
        checkOutput("rst_in_ready", bus.in_ready_o, 1'b0);
        checkOutput("rst_out_valid", bus.out_valid_o, 1'b0);
        checkOutput("rst_out_data", bus.out_data_o, 128'd0);
        checkOutput("rst_out_last", bus.out_last_o, 1'b0);
        checkOutput("rst8_busy", busy8, 1'b0);

        $display("[TB] SP800-38A F.5.1 encrypt, then decrypt started while last beat drains");
        startStream(IV);
        for (int i = 0; i < 4; i++) applyStimulus(PT[i], i == 3, CT[i]);
        startStream(IV);
        for (int i = 0; i < 4; i++) applyStimulus(CT[i], i == 3, PT[i]);
        drain();
        checkOutput("f51_idle", busy, 1'b0);
        checkOutput("f51_nowrap", wrap, 1'b0);

        $display("[TB] key not ready holds REQ, then one request");
        keyReady = 1'b0;
        startStream(IV2);
        idle(6);
        checkOutput("nokey_no_encrypt", 128'(encCount), 128'd0);
        checkOutput("nokey_busy", busy, 1'b1);
        keyReady = 1'b1;
        idle(4);
        checkOutput("key_one_pulse", 128'(encCount), 128'd1);

        $display("[TB] backpressure and 32-bit counter wrap");
        applyStimulus(genData(0), 1'b0, genData(0) ^ ksFn(ctrAt(IV2, 0, 32)));
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = genData(1);
        bus.in_last_i   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_out_valid", bus.out_valid_o, 1'b1);
            checkOutput("stall_out_data", bus.out_data_o, sbQ[0].d);
            checkOutput("stall_in_ready", bus.in_ready_o, 1'b0);
            step(acc);
            checkOutput("stall_no_accept", acc, 1'b0);
        end
        bus.out_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) applyStimulus(genData(k), k == 3, genData(k) ^ ksFn(ctrAt(IV2, k, 32)));
        drain();
        checkOutput("wrap32_set", wrap, 1'b1);

        $display("[TB] reset in WAIT followed by stray completions");
        startStream(IV);
        for (int i = 0; i < 20 && encCount == 0; i++) step(acc);
        checkOutput("reached_wait", 128'(encCount), 128'd1);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        strayDone = 1'b1;
        step(acc);
        strayDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("abort_busy", busy, 1'b0);
            checkOutput("abort_out_valid", bus.out_valid_o, 1'b0);
            checkOutput("abort_in_ready", bus.in_ready_o, 1'b0);
            checkOutput("abort_encrypt", bus.aes_encrypt_o, 1'b0);
            step(acc);
        end
        checkOutput("abort_block", bus.aes_block_o, 128'd0);
        checkOutput("abort_out_data", bus.out_data_o, 128'd0);

        $display("[TB] 8-bit counter wrap");
        iv8 = IV8;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        bus8.in_valid_i = 1'b1;
        bus8.in_data_i  = genData(10);
        bus8.in_last_i  = 1'b0;
        nOut = 0;
        nAcc = 0;
        for (int c = 0; c < 200 && nOut < 2; c++) begin
            #1;
            if (bus8.aes_encrypt_o) blk8.push_back(bus8.aes_block_o);
            if (bus8.out_valid_o) begin
                checkOutput("w8_out_data", bus8.out_data_o, genData(10 + nOut) ^ ksFn(ctrAt(IV8, nOut, 8)));
                nOut++;
            end
            accNow = bus8.in_valid_i && bus8.in_ready_o;
            @(posedge clk);
            #1;
            if (accNow) begin
                nAcc++;
                bus8.in_data_i  = genData(10 + nAcc);
                bus8.in_last_i  = (nAcc == 1);
                bus8.in_valid_i = (nAcc < 2);
            end
        end
        checkOutput("w8_beats", 128'(nOut), 128'd2);
        checkOutput("w8_requests", 128'(blk8.size()), 128'd2);
        if (blk8.size() == 2) begin
            checkOutput("w8_block0", blk8[0], IV8);
            checkOutput("w8_block1", blk8[1], 128'h00112233445566778899aabbccddee00);
        end
        checkOutput("w8_wrap_set", wrap8, 1'b1);
        checkOutput("w8_idle", busy8, 1'b0);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checkOutput("w8_wrap_cleared", wrap8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
